// File: rtl/level_disp_pkg.sv
// Shared constants, state encoding and display constants for the level display
// encoder: widths, saturation limit, blank nibble and FSM states.
package level_disp_pkg;

  localparam int VALUE_W    = 27;
  localparam int NUM_DIGITS = 8;
  localparam int NUMBER_W   = 4 * NUM_DIGITS;
  localparam int CNT_W      = $clog2(VALUE_W + 1);

  localparam logic [VALUE_W-1:0] MAX_VALUE    = 27'd99_999_999;
  localparam logic [3:0]         BLANK_NIBBLE = 4'hF;
  localparam logic [CNT_W-1:0]   CNT_LAST     = CNT_W'(VALUE_W);

  localparam logic [NUMBER_W-1:0] SAT_NUMBER   = {NUM_DIGITS{4'h9}};
  localparam logic [NUMBER_W-1:0] RESET_NUMBER = {{(NUM_DIGITS-1){BLANK_NIBBLE}}, 4'h0};

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CONVERT = 2'd1;
  localparam logic [1:0] ST_BLANK   = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    CONVERT = ST_CONVERT,
    BLANK   = ST_BLANK
  } state_t;

endpackage

// File: rtl/dabble_digit_adj.sv
// One BCD digit of the double-dabble step: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next digit.
module dabble_digit_adj (
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;

endmodule

// File: rtl/level_bcd_encoder.sv
// Binary fixed-point level reading to 8-digit BCD display word with leading
// blanks and decimal-point mask, converted serially by double dabble.
module level_bcd_encoder
  import level_disp_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [VALUE_W-1:0]  value,
  input  logic [2:0]          frac_digits,
  output logic [NUMBER_W-1:0] number,
  output logic [7:0]          dp_list,
  output logic                busy,
  output logic                done,
  output logic                overflow
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [VALUE_W-1:0]  bin_q;
  logic [NUMBER_W-1:0] bcd_q;
  logic [NUMBER_W-1:0] bcd_adj;
  logic [NUMBER_W-1:0] blanked;
  logic [2:0]          frac_q;
  logic                sat_q;
  logic                lead;
  logic [NUMBER_W-1:0] number_q;
  logic [7:0]          dp_q;
  logic                done_q;
  logic                ovf_q;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : gen_adj
    dabble_digit_adj u_adj (
      .digit_in  (bcd_q[4*k +: 4]),
      .digit_out (bcd_adj[4*k +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // The counter idles one cycle at CNT_LAST after the final shift before BLANK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CONVERT;
      CONVERT: if (cnt_q == CNT_LAST) state_d = BLANK;
      BLANK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every variable driven here gets a value before any branch, so no latch can form.
  always_comb begin
    blanked = bcd_q;
    lead    = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (lead && (k > int'(frac_q)) && (bcd_q[4*k +: 4] == 4'd0))
        blanked[4*k +: 4] = BLANK_NIBBLE;
      else
        lead = 1'b0;
    end
  end

  // NOTE: sequential state uses <= only; reads in the same edge see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      bin_q    <= '0;
      bcd_q    <= '0;
      frac_q   <= '0;
      sat_q    <= 1'b0;
      number_q <= RESET_NUMBER;
      dp_q     <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            bin_q  <= value;
            frac_q <= frac_digits;
            sat_q  <= (value > MAX_VALUE);
            bcd_q  <= '0;
            cnt_q  <= '0;
          end
        end
        CONVERT: begin
          if (cnt_q != CNT_LAST) begin
            bcd_q <= {bcd_adj[NUMBER_W-2:0], bin_q[VALUE_W-1]};
            bin_q <= {bin_q[VALUE_W-2:0], 1'b0};
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        BLANK: begin
          number_q <= sat_q ? SAT_NUMBER : blanked;
          dp_q     <= (frac_q == 3'd0) ? 8'h00 : (8'h01 << frac_q);
          ovf_q    <= sat_q;
          done_q   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign number   = number_q;
  assign dp_list  = dp_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_level_bcd_encoder.sv
// Self-checking bench for level_bcd_encoder: behavioural decimal model checked
// every cycle, plus directed cases with hand-computed display words.
module tb_level_bcd_encoder;

  localparam int LATENCY = 29;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [26:0] value;
  logic [2:0]  frac_digits;
  logic [31:0] number;
  logic [7:0]  dp_list;
  logic        busy;
  logic        done;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  level_bcd_encoder dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .value       (value),
    .frac_digits (frac_digits),
    .number      (number),
    .dp_list     (dp_list),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Decimal reference: split into digits with /10 and %10, blank above the
  // highest non-zero digit but never at or right of the units digit.
  function automatic void model_conv(input logic [26:0] v, input logic [2:0] f,
                                     output logic [31:0] num, output logic [7:0] dp,
                                     output logic ovf);
    int unsigned x;
    int          d[8];
    int          top;
    ovf = (v > 27'd99_999_999);
    dp  = (f == 3'd0) ? 8'h00 : (8'h01 << f);
    num = 32'h9999_9999;
    if (!ovf) begin
      x   = 32'(v);
      top = 0;
      for (int i = 0; i < 8; i++) begin
        d[i] = int'(x % 10);
        x    = x / 10;
        if (d[i] != 0) top = i;
      end
      for (int i = 0; i < 8; i++)
        num[4*i +: 4] = (i > int'(f) && i > top) ? 4'hF : 4'(d[i]);
    end
  endfunction

  logic [31:0] m_number;
  logic [7:0]  m_dp;
  logic        m_ovf, m_busy, m_done;
  logic [26:0] m_val;
  logic [2:0]  m_frac;
  int          m_count;
  bit          armed = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_number = 32'hFFFF_FFF0;
      m_dp     = 8'h00;
      m_ovf    = 1'b0;
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_count  = 0;
      armed    = 1'b1;
    end else if (armed) begin
      m_done = 1'b0;
      if (m_busy) begin
        m_count--;
        if (m_count == 0) begin
          model_conv(m_val, m_frac, m_number, m_dp, m_ovf);
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end else if (start) begin
        m_val   = value;
        m_frac  = frac_digits;
        m_busy  = 1'b1;
        m_count = LATENCY;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("cyc_number",   64'(number),   64'(m_number));
      check("cyc_dp_list",  64'(dp_list),  64'(m_dp));
      check("cyc_overflow", 64'(overflow), 64'(m_ovf));
      check("cyc_busy",     64'(busy),     64'(m_busy));
      check("cyc_done",     64'(done),     64'(m_done));
    end
  end

  task automatic start_conv(input logic [26:0] v, input logic [2:0] f);
    value       = v;
    frac_digits = f;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, input bit noise);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (noise) begin
        start       = 1'($urandom_range(0, 1));
        value       = 27'($urandom);
        frac_digits = 3'($urandom_range(0, 7));
      end
    end
    start = 1'b0;
  endtask

  task automatic run_directed(input string tag, input logic [26:0] v, input logic [2:0] f,
                              input logic [31:0] e_num, input logic [7:0] e_dp, input logic e_ovf);
    int lat;
    start_conv(v, f);
    wait_done(lat, 1'b0);
    check({tag, "_latency"},  64'(lat),      64'(LATENCY));
    check({tag, "_number"},   64'(number),   64'(e_num));
    check({tag, "_dp_list"},  64'(dp_list),  64'(e_dp));
    check({tag, "_overflow"}, 64'(overflow), 64'(e_ovf));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_number"},   64'(number),   64'h0000_0000_FFFF_FFF0);
    check({tag, "_dp_list"},  64'(dp_list),  64'h0);
    check({tag, "_overflow"}, 64'(overflow), 64'h0);
    check({tag, "_busy"},     64'(busy),     64'h0);
    check({tag, "_done"},     64'(done),     64'h0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dones, first, lat, gap;
    logic [26:0] rv;

    rst = 1'b1; start = 1'b0; value = '0; frac_digits = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

    // Directed cases; each starts in the done cycle of the previous one.
    run_directed("v1234_f2",   27'd1234,        3'd2, 32'hFFFF_1234, 8'h04, 1'b0);
    run_directed("v5_f2",      27'd5,           3'd2, 32'hFFFF_F005, 8'h04, 1'b0);
    run_directed("v0_f0",      27'd0,           3'd0, 32'hFFFF_FFF0, 8'h00, 1'b0);
    run_directed("v100M_f1",   27'd100_000_000, 3'd1, 32'h9999_9999, 8'h02, 1'b1);
    run_directed("vmax_f7",    27'd99_999_999,  3'd7, 32'h9999_9999, 8'h80, 1'b0);
    run_directed("v10_f0",     27'd10,          3'd0, 32'hFFFF_FF10, 8'h00, 1'b0);
    run_directed("v5_f7",      27'd5,           3'd7, 32'h0000_0005, 8'h80, 1'b0);
    run_directed("vtop_f3",    27'h7FF_FFFF,    3'd3, 32'h9999_9999, 8'h08, 1'b1);

    // Start pulsed mid-conversion with other operands must be ignored.
    start_conv(27'd42, 3'd0);
    dones = 0; first = -1;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        dones++;
        if (first < 0) first = k;
      end
      if (k == 5) begin
        start = 1'b1; value = 27'd777; frac_digits = 3'd3;
      end else begin
        start = 1'b0;
      end
    end
    check("ignore_done_count", 64'(dones),   64'd1);
    check("ignore_latency",    64'(first),   64'(LATENCY));
    check("ignore_number",     64'(number),  64'h0000_0000_FFFF_FF42);
    check("ignore_dp_list",    64'(dp_list), 64'h0);

    // Reset during conversion aborts it without a done pulse.
    start_conv(27'd123, 3'd1);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_state("midreset");
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    check("midreset_no_done", 64'(dones), 64'd0);
    run_directed("after_reset", 27'd123, 3'd1, 32'hFFFF_F123, 8'h02, 1'b0);

    // Randomized conversions with input noise while busy.
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 3))
        0:       rv = 27'($urandom_range(0, 999));
        1:       rv = 27'($urandom);
        2:       rv = 27'(99_999_990 + $urandom_range(0, 20));
        default: rv = 27'($urandom_range(0, 99_999_999));
      endcase
      start_conv(rv, 3'($urandom_range(0, 7)));
      wait_done(lat, 1'b1);
      check("rand_latency", 64'(lat), 64'(LATENCY));
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
